// File: rtl/flappy_game_seq.sv
// flappy_game_seq
//   Frame-rate game sequencer for the Flappy Bird VGA datapath. Walks the game
//   through ATTRACT -> READY -> PLAY -> DYING -> OVER on vsync frame ticks,
//   drives the run enables and per-frame strobes for the bird-physics and
//   pipe-scroll logic, keeps a saturating 3-digit BCD score and best score, and
//   arbitrates sound-effect requests into a one-entry valid/ready slot.
//
// Ports
//   clk, reset        system clock; asynchronous active-high reset
//   frame_tick        one-cycle pulse per vsync; all state changes happen here
//   flap_req          flap level; its rising edge is the flap event
//   pipe_passed       one-cycle pulse when a pipe clears the bird
//   hit_pipe          collision level, sampled on frame_tick
//   hit_ground        floor-contact level, sampled on frame_tick
//   state             0 ATTRACT, 1 READY, 2 PLAY, 3 DYING, 4 OVER
//   world_run         pipes scroll
//   bird_run          bird physics advance
//   world_reset       one-cycle pulse: re-seed pipes and bird
//   frame_go          one-cycle update strobe the cycle after every frame_tick
//   flap_pulse        with frame_go: apply flap velocity this frame
//   score, best       3-digit BCD
//   sfx_valid, sfx_id pending sound request (1 FLAP, 2 SCORE, 3 HIT)
//   sfx_ready         audio engine accepts when valid and ready
module flappy_game_seq #(
  parameter int READY_FRAMES = 30,
  parameter int DEATH_FRAMES = 90,
  parameter int OVER_HOLD    = 45
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        flap_req,
  input  logic        pipe_passed,
  input  logic        hit_pipe,
  input  logic        hit_ground,
  output logic [2:0]  state,
  output logic        world_run,
  output logic        bird_run,
  output logic        world_reset,
  output logic        frame_go,
  output logic        flap_pulse,
  output logic [11:0] score,
  output logic [11:0] best,
  output logic        sfx_valid,
  output logic [1:0]  sfx_id,
  input  logic        sfx_ready
);

  typedef enum logic [2:0] {
    S_ATTRACT = 3'd0,
    S_READY   = 3'd1,
    S_PLAY    = 3'd2,
    S_DYING   = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  localparam logic [1:0] SFX_NONE  = 2'd0;
  localparam logic [1:0] SFX_FLAP  = 2'd1;
  localparam logic [1:0] SFX_SCORE = 2'd2;
  localparam logic [1:0] SFX_HIT   = 2'd3;

  localparam logic [7:0] READY_LAST = 8'(READY_FRAMES - 1);
  localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] OVER_MIN   = 8'(OVER_HOLD - 1);

  // BCD increment with per-digit carry, holding at 999.
  function automatic logic [11:0] bcd_inc_sat(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v != 12'h999) begin
      if (v[3:0] != 4'd9) begin
        r[3:0] = v[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) begin
          r[7:4] = v[7:4] + 4'd1;
        end else begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic        flap_prev_q;
  logic        flap_pend_q, flap_pend_d;
  logic        pass_pend_q, pass_pend_d;
  logic        world_run_q, world_run_d;
  logic        bird_run_q, bird_run_d;
  logic        world_reset_q, world_reset_d;
  logic        frame_go_q, frame_go_d;
  logic        flap_pulse_q, flap_pulse_d;
  logic [11:0] score_q, score_d;
  logic [11:0] best_q, best_d;
  logic        sfx_valid_q, sfx_valid_d;
  logic [1:0]  sfx_id_q, sfx_id_d;

  logic        flap_now;
  logic        pass_now;
  logic [1:0]  req_id;
  logic        slot_busy;

  // Events arriving on the tick cycle itself count for that frame.
  assign flap_now = flap_pend_q | (flap_req & ~flap_prev_q);
  assign pass_now = pass_pend_q | pipe_passed;

  always_comb begin
    state_d       = state_q;
    score_d       = score_q;
    best_d        = best_q;
    world_reset_d = 1'b0;
    flap_pulse_d  = 1'b0;
    frame_go_d    = frame_tick;
    req_id        = SFX_NONE;
    fcnt_d        = fcnt_q;
    flap_pend_d   = frame_tick ? 1'b0 : flap_now;
    pass_pend_d   = frame_tick ? 1'b0 : pass_now;

    if (frame_tick) begin
      case (state_q)
        S_ATTRACT: begin
          if (flap_now) begin
            state_d       = S_READY;
            world_reset_d = 1'b1;
            score_d       = 12'h000;
          end
        end
        S_READY: begin
          if (fcnt_q == READY_LAST) begin
            state_d      = S_PLAY;
            flap_pulse_d = 1'b1;
            req_id       = SFX_FLAP;
          end
        end
        S_PLAY: begin
          if (hit_pipe || hit_ground) begin
            state_d = S_DYING;
            req_id  = SFX_HIT;
          end else begin
            // SCORE is assigned after FLAP so it wins when both land together.
            if (flap_now) begin
              flap_pulse_d = 1'b1;
              req_id       = SFX_FLAP;
            end
            if (pass_now) begin
              score_d = bcd_inc_sat(score_q);
              req_id  = SFX_SCORE;
            end
          end
        end
        S_DYING: begin
          if (hit_ground || (fcnt_q == DEATH_LAST)) begin
            state_d = S_OVER;
            // Valid BCD orders the same as binary, so a plain compare works.
            if (score_q > best_q) best_d = score_q;
          end
        end
        default: begin
          if (flap_now && (fcnt_q >= OVER_MIN)) begin
            state_d       = S_READY;
            world_reset_d = 1'b1;
            score_d       = 12'h000;
          end
        end
      endcase

      // Saturate rather than wrap so a long OVER idle never re-arms the hold.
      if (state_d != state_q) fcnt_d = 8'd0;
      else if (fcnt_q != 8'hFF) fcnt_d = fcnt_q + 8'd1;
    end

    world_run_d = (state_d == S_PLAY);
    bird_run_d  = (state_d == S_PLAY) || (state_d == S_DYING);

    // One-entry slot: acceptance frees it in the same cycle a new request
    // may load; a lower-priority request than the held one is dropped.
    slot_busy   = sfx_valid_q & ~sfx_ready;
    sfx_valid_d = slot_busy;
    sfx_id_d    = slot_busy ? sfx_id_q : SFX_NONE;
    if ((req_id != SFX_NONE) && (!slot_busy || (req_id >= sfx_id_q))) begin
      sfx_valid_d = 1'b1;
      sfx_id_d    = req_id;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_ATTRACT;
      fcnt_q        <= 8'd0;
      flap_prev_q   <= 1'b0;
      flap_pend_q   <= 1'b0;
      pass_pend_q   <= 1'b0;
      world_run_q   <= 1'b0;
      bird_run_q    <= 1'b0;
      world_reset_q <= 1'b0;
      frame_go_q    <= 1'b0;
      flap_pulse_q  <= 1'b0;
      score_q       <= 12'h000;
      best_q        <= 12'h000;
      sfx_valid_q   <= 1'b0;
      sfx_id_q      <= SFX_NONE;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      flap_prev_q   <= flap_req;
      flap_pend_q   <= flap_pend_d;
      pass_pend_q   <= pass_pend_d;
      world_run_q   <= world_run_d;
      bird_run_q    <= bird_run_d;
      world_reset_q <= world_reset_d;
      frame_go_q    <= frame_go_d;
      flap_pulse_q  <= flap_pulse_d;
      score_q       <= score_d;
      best_q        <= best_d;
      sfx_valid_q   <= sfx_valid_d;
      sfx_id_q      <= sfx_id_d;
    end
  end

  assign state       = state_q;
  assign world_run   = world_run_q;
  assign bird_run    = bird_run_q;
  assign world_reset = world_reset_q;
  assign frame_go    = frame_go_q;
  assign flap_pulse  = flap_pulse_q;
  assign score       = score_q;
  assign best        = best_q;
  assign sfx_valid   = sfx_valid_q;
  assign sfx_id      = sfx_id_q;

endmodule

// File: doc/flappy_game_seq.md
# flappy_game_seq

Frame-rate game sequencer for the Flappy Bird VGA datapath. It tracks the game phase (attract, ready, play, dying, over) from vsync frame ticks, flap requests and collision flags, and drives the run enables and per-frame update strobes consumed by the bird-physics and pipe-scroll logic. It keeps a BCD score and best score, and arbitrates sound-effect requests into a single valid/ready slot toward the audio effects engine.

## Interface
- READY_FRAMES, 30: frame ticks spent in READY before play starts.
- DEATH_FRAMES, 90: maximum frame ticks in DYING before forcing OVER.
- OVER_HOLD, 45: minimum frame ticks in OVER before a flap may restart.

- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- frame_tick  in  1  one-cycle pulse on the vsync rising edge.
- flap_req  in  1  flap request level (register bit or key); rising edge is the event.
- pipe_passed  in  1  one-cycle pulse when a pipe's trailing edge crosses BIRD_X.
- hit_pipe  in  1  level: bird overlaps a pipe; sampled at frame_tick.
- hit_ground  in  1  level: bird at the floor; sampled at frame_tick.
- state  out  3  0 ATTRACT, 1 READY, 2 PLAY, 3 DYING, 4 OVER.
- world_run  out  1  pipes scroll.
- bird_run  out  1  bird physics advance.
- world_reset  out  1  one-cycle pulse: re-seed pipes and bird to start positions.
- frame_go  out  1  one-cycle update strobe, the cycle after frame_tick.
- flap_pulse  out  1  coincident with frame_go; apply flap velocity this frame.
- score  out  12  3-digit BCD current score.
- best  out  12  3-digit BCD best score.
- sfx_valid  out  1  sound request pending.
- sfx_id  out  2  1 FLAP, 2 SCORE, 3 HIT.
- sfx_ready  in  1  audio engine accepts when valid and ready.

## Operation
- Event latches: flap_pend is set on a flap_req rising edge (previous-sample register). pass_pend is set on pipe_passed. Both are evaluated and cleared on the frame_tick cycle. An event arriving on the same cycle as frame_tick counts for that frame.
- Frame counter fcnt (8 bit) clears on every state change and increments on each frame_tick otherwise.
- Every state transition happens on a clock edge where frame_tick=1.
- ATTRACT: world_run=0, bird_run=0. flap_pend → READY with world_reset, score ← 0.
- READY: world_run=0, bird_run=0, flaps discarded. When fcnt = READY_FRAMES-1 → PLAY, with flap_pulse on that frame.
- PLAY: world_run=1, bird_run=1.
  - Priority at each tick: (hit_pipe|hit_ground) → DYING, issue HIT. Otherwise pass_pend → score+1, issue SCORE, and independently flap_pend → flap_pulse, issue FLAP.
  - If score and flap fall on the same frame, the slot rule keeps SCORE.
- DYING: world_run=0, bird_run=1, flaps discarded. hit_ground or fcnt = DEATH_FRAMES-1 → OVER.
  - On that transition, best ← score if score > best.
- OVER: both run enables 0. flap_pend with fcnt ≥ OVER_HOLD-1 → READY with world_reset, score ← 0. Earlier flaps are discarded.
- Score: BCD increment with per-digit carry. Saturates at 999; best is cleared only by reset.
- SFX slot (one entry):
  - A new request loads when the slot is empty or new id ≥ held id. A lower-priority request is dropped.
  - Acceptance (valid & ready) empties the slot. A request on the acceptance cycle loads into the emptied slot.

## Timing
- Reset values: state=ATTRACT, all enables/pulses 0, score=0, best=0, sfx_valid=0, sfx_id=0, latches and fcnt cleared. Reset mid-game returns to ATTRACT immediately, asynchronously.
- frame_tick at cycle T:
  - state, world_run, bird_run, score and sfx slot update at T+1.
  - world_reset, frame_go and flap_pulse are high during T+1 only.
- All outputs are registered. No combinational path from inputs to outputs.
- frame_go pulses once per frame_tick in every state, so downstream can redraw while halted.
- sfx_valid remains high with a stable sfx_id until accepted or overwritten by equal/higher priority.

## Test plan
- Start: reset, flap edge, 1 tick → state=1 and world_reset pulse at T+1. READY_FRAMES more ticks → state=2 with flap_pulse and frame_go together; sfx_id=1.
- Scoring: in PLAY, 12 pipe_passed pulses, each in its own frame → score=0x012. Pre-load 999, one more pulse → score stays 0x999 and SCORE is still issued.
- Collision priority: pipe_passed and hit_pipe in the same frame → state=3, score unchanged, sfx_id=3, world_run=0, bird_run=1.
- Death/best: score=0x007, best=0x005. hit_ground in DYING → state=4, best=0x007. Flap at fcnt=10 ignored. Flap after OVER_HOLD ticks → READY, score=0, best kept.
- SFX arbitration: sfx_ready=0, issue FLAP then SCORE then FLAP → slot holds 2. Raise ready with HIT arriving the same cycle → id 2 accepted, then slot=3.
- Async reset: assert reset mid-PLAY between clock edges → outputs at reset values before the next clk edge. Deassert → ATTRACT holds until a flap.
